riscv_irq_scheduler: RTL
========================

# riscv_irq_scheduler

Testbench-side interrupt scheduler for RI5CY/Zeroriscy perturbation benches. It collects interrupt requests from three generators (timer, random, standard/PC-triggered) and latches each one as pending. It arbitrates the pending requests by fixed priority and drives a single `irq_o`/`irq_id_o` request to the core, holding it until the core acknowledges or a timeout expires. It sits between the bench interrupt generators and the core interrupt inputs, and replaces ad-hoc muxing with a handshaked, one-at-a-time sequence.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles `irq_o` stays asserted without acknowledge before the request is dropped; range 1..65535.
- `HOLDOFF_CYCLES`, default 2: cycles `irq_o` stays low after each acknowledge or timeout before the next request; 0 means no gap.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `req_timer_i` in 1: timer generator request, sampled each edge.
- `id_timer_i` in 5: interrupt ID for the timer request.
- `req_rnd_i` in 1: random generator request.
- `id_rnd_i` in 5: interrupt ID for the random request.
- `req_std_i` in 1: standard/PC-triggered generator request.
- `id_std_i` in 5: interrupt ID for the standard request.
- `irq_ack_i` in 1: core acknowledge, one-cycle pulse.
- `irq_ack_id_i` in 5: ID the core is acknowledging.
- `irq_o` out 1: interrupt request to the core.
- `irq_id_o` out 5: ID of the asserted request.
- `grant_o` out 3: one-hot pulse {std, rnd, timer} when that source's request is acknowledged.
- `pending_o` out 3: per-source pending flags {std, rnd, timer}.
- `timeout_o` out 1: one-cycle pulse when a request is dropped by timeout.
- `busy_o` out 1: high when the FSM is not in IDLE.

## Operation
- Valid IDs are 3, 7, 11 and 16..30. A request that carries any other ID is ignored and is not latched.
- Each source has a pending flag and a captured ID.
  - A valid request sets the flag and captures the ID only when the flag is clear.
  - A request to an already-pending source is dropped, and the captured ID is kept.
- Arbitration priority is timer > rnd > std. It is evaluated only in IDLE, over the pending flags OR'd with valid requests arriving in the same cycle. There is no preemption while a request is asserted.
- FSM states:
  - IDLE: if any candidate exists, register the winner's ID into `irq_id_o`, set `irq_o`=1, clear the wait counter, and go to ASSERT. Otherwise stay in IDLE.
  - ASSERT: `irq_o`=1 and the wait counter increments each cycle.
    - If `irq_ack_i`=1 and `irq_ack_id_i`==`irq_id_o`: clear the served pending flag, pulse the matching `grant_o` bit, drop `irq_o`, and go to HOLDOFF.
    - If `irq_ack_i`=1 with a mismatched ID: ignore it and stay in ASSERT.
    - If the counter reaches `TIMEOUT_CYCLES`-1 with no matching acknowledge: clear the served pending flag, pulse `timeout_o`, drop `irq_o`, and go to HOLDOFF.
  - HOLDOFF: `irq_o`=0 and the counter counts down from `HOLDOFF_CYCLES`. At 0, go to IDLE. When `HOLDOFF_CYCLES`=0, the FSM goes directly to IDLE.
- `irq_id_o` holds its last value while `irq_o`=0.
- A matching acknowledge and a timeout in the same cycle resolve as an acknowledge.
- If a pending flag is cleared (acknowledge or timeout) and a new valid request arrives for the same source in the same cycle, the set wins: the flag ends up set and the new ID is captured.

## Timing
- All outputs are registered.
- Reset values: `irq_o`=0, `irq_id_o`=0, `grant_o`=0, `pending_o`=0, `timeout_o`=0, `busy_o`=0. FSM state is IDLE and all counters are 0.
- Reset asserted mid-ASSERT: `irq_o`=0 at the next edge, all pending flags are lost, and no grant or timeout pulse is produced.
- Latency, with the FSM in IDLE: a request sampled at edge N gives `irq_o`=1 with the correct `irq_id_o` after edge N.
- Acknowledge sampled at edge M:
  - `irq_o`=0 and the `grant_o` pulse both appear after edge M.
  - The next `irq_o` rises after edge M+`HOLDOFF_CYCLES`+1, at the earliest.
- Timeout: if `irq_o` rises after edge N and no acknowledge arrives, `irq_o` falls after edge N+`TIMEOUT_CYCLES`, together with the `timeout_o` pulse.
- The wait counter is 16 bits and saturates; it never wraps.

## Configuration
- Macro `IRQ_SCHED_TIMEOUT_EN`.
- Defined: timeout logic is present as described above.
- Undefined:
  - The timeout counter and `TIMEOUT_CYCLES` checks are removed.
  - `timeout_o` is tied to 0.
  - ASSERT is left only on a matching acknowledge, so the request waits for the core indefinitely.

## Test plan
- Reset, then `req_std_i`=1 with `id_std_i`=16 for one cycle:
  - `irq_o`=1 and `irq_id_o`=16 on the next cycle.
  - Acknowledge with ID 16 gives `grant_o`=3'b100.
  - `irq_o` is low for 2 cycles, then `busy_o`=0.
- Timer (ID 7) and rnd (ID 20) requested in the same cycle:
  - ID 7 is served first.
  - After its acknowledge and the 2-cycle holdoff, ID 20 is asserted.
  - `pending_o` goes 3'b011 → 3'b010 → 3'b000.
- Request with ID 5, then request with ID 0: nothing is latched, and `irq_o` stays 0.
- With `TIMEOUT_CYCLES`=4 and no acknowledge: `irq_o` is high for exactly 4 cycles, `timeout_o` pulses once, and the pending flag clears.
  - With `IRQ_SCHED_TIMEOUT_EN` undefined: `irq_o` stays high for more than 1000 cycles.
- Acknowledge with ID 11 while `irq_id_o`=7: ignored and `irq_o` stays 1. A second request with ID 25 on the pending timer source is dropped, and `irq_id_o` stays 7.
- Assert `rst_i` for one cycle during ASSERT: all outputs are 0 on the next cycle, and no `grant_o` pulse appears.

Source files
------------

// File: rtl/riscv_irq_scheduler.sv
// riscv_irq_scheduler: latches timer/rnd/std interrupt requests and issues them one at a time to the core.
// Define IRQ_SCHED_TIMEOUT_EN to drop an unacknowledged request after TIMEOUT_CYCLES.
module riscv_irq_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_timer_i,
    input  logic [4:0] id_timer_i,
    input  logic       req_rnd_i,
    input  logic [4:0] id_rnd_i,
    input  logic       req_std_i,
    input  logic [4:0] id_std_i,
    input  logic       irq_ack_i,
    input  logic [4:0] irq_ack_id_i,
    output logic       irq_o,
    output logic [4:0] irq_id_o,
    output logic [2:0] grant_o,
    output logic [2:0] pending_o,
    output logic       timeout_o,
    output logic       busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;

    localparam bit          HOLD_EN   = (HOLDOFF_CYCLES != 0);
    localparam logic [15:0] HOLD_LOAD = HOLD_EN ? 16'(HOLDOFF_CYCLES - 1) : 16'd0;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("riscv_irq_scheduler: TIMEOUT_CYCLES must be in 1..65535");
    end

    function automatic logic id_valid(input logic [4:0] id);
        return (id == 5'd3) || (id == 5'd7) || (id == 5'd11) ||
               ((id >= 5'd16) && (id <= 5'd30));
    endfunction

    function automatic logic [2:0] pick_first(input logic [2:0] cand);
        if (cand[0]) return 3'b001;
        if (cand[1]) return 3'b010;
        if (cand[2]) return 3'b100;
        return 3'b000;
    endfunction

    logic [1:0]       state_q;
    logic [15:0]      hold_q;
    logic [2:0]       pend_q;
    logic [2:0][4:0]  cap_id_q;
    logic [2:0]       srv_q;

    logic [2:0]       req_vec;
    logic [2:0][4:0]  id_vec;
    logic [2:0]       vreq;
    logic [2:0]       cand;
    logic [2:0]       win;
    logic [4:0]       win_id;
    logic             ack_match;
    logic             tmo_hit;
    logic [2:0]       clr;

    assign req_vec = {req_std_i, req_rnd_i, req_timer_i};
    assign id_vec  = {id_std_i, id_rnd_i, id_timer_i};

    assign vreq[0] = req_vec[0] && id_valid(id_vec[0]);
    assign vreq[1] = req_vec[1] && id_valid(id_vec[1]);
    assign vreq[2] = req_vec[2] && id_valid(id_vec[2]);

    // Candidates include same-cycle arrivals so an idle scheduler responds in one edge.
    assign cand = pend_q | vreq;
    assign win  = pick_first(cand);

    always_comb begin
        win_id = 5'd0;
        for (int i = 0; i < 3; i++) begin
            if (win[i]) win_id = pend_q[i] ? cap_id_q[i] : id_vec[i];
        end
    end

    assign ack_match = (state_q == S_ASSERT) && irq_ack_i && (irq_ack_id_i == irq_id_o);

`ifdef IRQ_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != S_ASSERT)) begin
            wait_q <= 16'd0;
        end else if (wait_q != 16'hFFFF) begin
            wait_q <= wait_q + 16'd1;
        end
    end

    assign tmo_hit = (state_q == S_ASSERT) && (wait_q == TMO_LAST) && !ack_match;
`else
    assign tmo_hit = 1'b0;
`endif

    assign clr       = (ack_match || tmo_hit) ? srv_q : 3'b000;
    assign pending_o = pend_q;

    // A fresh request outranks a same-cycle clear of its own flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= (pend_q & ~clr) | vreq;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (vreq[i] && !(pend_q[i] && !clr[i])) cap_id_q[i] <= id_vec[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            hold_q    <= 16'd0;
            srv_q     <= 3'b000;
            irq_o     <= 1'b0;
            irq_id_o  <= 5'd0;
            grant_o   <= 3'b000;
            timeout_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            grant_o   <= 3'b000;
            timeout_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|cand) begin
                        state_q  <= S_ASSERT;
                        srv_q    <= win;
                        irq_o    <= 1'b1;
                        irq_id_o <= win_id;
                        busy_o   <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (ack_match || tmo_hit) begin
                        irq_o     <= 1'b0;
                        grant_o   <= ack_match ? srv_q : 3'b000;
                        timeout_o <= tmo_hit;
                        if (HOLD_EN) begin
                            state_q <= S_HOLDOFF;
                            hold_q  <= HOLD_LOAD;
                        end else begin
                            state_q <= S_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold_q == 16'd0) begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    irq_o   <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
